if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the fetch program counter, presents it to instruction memory, and
// latches the returned word (plus PC+4) into the IF/ID register. A small
// BOOT/RUN/HOLD state machine sequences start-up and stalls; a downstream
// redirect overrides everything except reset.
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   synchronous active-low reset
//   start_pc        in   PC loaded while in reset
//   stall           in   hold PC and IF/ID register
//   redirect        in   taken branch / jump, wins over stall
//   redirect_pc     in   redirect target (bits [1:0] are dropped)
//   imem_addr       out  fetch address, always equal to program_counter
//   imem_rdata      in   instruction at imem_addr, same cycle
//   program_counter out  current fetch PC
//   ifid_instr      out  registered instruction for decode
//   ifid_pc_plus4   out  registered fetch address + 4
//   ifid_valid      out  ifid_instr is a real instruction
//   misalign_err    out  sticky flag: a redirect target was misaligned
//   fetch_count     out  saturating count of delivered instructions
// -----------------------------------------------------------------------------
module if_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] start_pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] program_counter,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid,
  output logic              misalign_err,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_fetch;

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ifid_instr;
  logic [DATA_W-1:0] r_ifid_pc_plus4;
  logic              r_ifid_valid;
  logic              r_misalign_err;
  logic [31:0]       r_fetch_count;

  logic [DATA_W-1:0] w_pc_plus4;
  logic [DATA_W-1:0] w_redirect_aligned;
  logic              w_redirect_misaligned;

  // Natural wrap modulo 2^DATA_W is intended.
  assign w_pc_plus4            = r_pc + DATA_W'(4);
  assign w_redirect_aligned    = {redirect_pc[DATA_W-1:2], 2'b00};
  assign w_redirect_misaligned = |redirect_pc[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and fetch enable. A fetch only happens in RUN with a clean
  // cycle; leaving BOOT or HOLD costs one edge with no fetch.
  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    if (redirect) begin
      w_state_next = RUN;
    end else begin
      case (r_state)
        BOOT: w_state_next = stall ? HOLD : RUN;
        RUN: begin
          if (stall) begin
            w_state_next = HOLD;
          end else begin
            w_fetch = 1'b1;
          end
        end
        HOLD:    w_state_next = stall ? HOLD : RUN;
        default: w_state_next = BOOT;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc            <= start_pc;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= '0;
      r_ifid_valid    <= 1'b0;
      r_misalign_err  <= 1'b0;
      r_fetch_count   <= '0;
    end else if (redirect) begin
      r_pc            <= w_redirect_aligned;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= '0;
      r_ifid_valid    <= 1'b0;
      if (w_redirect_misaligned) begin
        r_misalign_err <= 1'b1;
      end
    end else if (w_fetch) begin
      r_pc            <= w_pc_plus4;
      r_ifid_instr    <= imem_rdata;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= 1'b1;
      if (r_fetch_count != 32'hFFFF_FFFF) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr       = r_pc;
  assign program_counter = r_pc;
  assign ifid_instr      = r_ifid_instr;
  assign ifid_pc_plus4   = r_ifid_pc_plus4;
  assign ifid_valid      = r_ifid_valid;
  assign misalign_err    = r_misalign_err;
  assign fetch_count     = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// Instruction memory is an address-dependent function. The reference model
// tracks the architectural outputs plus one "skip next clean edge" bit, which
// captures the single dead edge after reset or after a stall ends.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] start_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] program_counter;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis, m_skip;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage #(
    .DATA_W   (32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_pc       (start_pc),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .program_counter(program_counter),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_valid     (ifid_valid),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behaviour of one rising edge, from the current inputs.
  task automatic model_edge();
    if (!rst_n) begin
      m_pc = start_pc; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_mis = 0; m_cnt = 0; m_skip = 1;
    end else if (redirect) begin
      m_pc = redirect_pc - (redirect_pc % 4);
      m_instr = NOP; m_pc4 = 0; m_valid = 0; m_skip = 0;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else if (stall) begin
      m_skip = 1;
    end else if (m_skip) begin
      m_skip = 0;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc4   = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
      m_pc    = m_pc4;
      m_valid = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"},    program_counter, m_pc);
    chk({ctx, ".addr"},  imem_addr,       m_pc);
    chk({ctx, ".instr"}, ifid_instr,      m_instr);
    chk({ctx, ".pc4"},   ifid_pc_plus4,   m_pc4);
    chk({ctx, ".valid"}, {31'b0, ifid_valid},   {31'b0, m_valid});
    chk({ctx, ".mis"},   {31'b0, misalign_err}, {31'b0, m_mis});
    chk({ctx, ".cnt"},   fetch_count,     m_cnt);
  endtask

  task automatic step(input string ctx, input logic r, input logic s,
                      input logic d, input logic [31:0] rpc);
    rst_n = r; stall = s; redirect = d; redirect_pc = rpc;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
    $display("step %s rst_n=%0b stall=%0b redir=%0b rpc=%h -> pc=%h valid=%0b cnt=%0d",
             ctx, r, s, d, rpc, program_counter, ifid_valid, fetch_count);
  endtask

  initial begin
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; start_pc = 32'd200;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_mis = 0; m_skip = 1;

    // Reset, boot, and free-running fetch.
    step("rst", 0, 0, 0, 0);
    step("rst", 0, 0, 0, 0);
    chk("reset_pc", program_counter, 32'd200);
    step("boot", 1, 0, 0, 0);
    chk("boot_valid", {31'b0, ifid_valid}, 32'd0);
    step("run", 1, 0, 0, 0);
    chk("first_instr", ifid_instr, mem_word(32'd200));
    chk("first_pc4", ifid_pc_plus4, 32'd204);
    for (int i = 0; i < 8; i++) step("run", 1, 0, 0, 0);
    chk("ten_edges_pc", program_counter, 32'd236);
    chk("ten_edges_cnt", fetch_count, 32'd9);

    // Stall at PC=212.
    step("rst", 0, 0, 0, 0);
    step("boot", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("run", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0);
    chk("stall_pc", program_counter, 32'd212);
    step("unstall", 1, 0, 0, 0);
    chk("unstall_pc", program_counter, 32'd212);
    step("run", 1, 0, 0, 0);
    chk("after_stall_pc4", ifid_pc_plus4, 32'd216);
    step("run", 1, 0, 0, 0);

    // Redirect beats stall at PC=220.
    chk("pre_redir_pc", program_counter, 32'd220);
    step("redir_stall", 1, 1, 1, 32'd400);
    chk("redir_pc", program_counter, 32'd400);
    chk("redir_instr", ifid_instr, NOP);
    step("run", 1, 0, 0, 0);
    chk("redir_pc4", ifid_pc_plus4, 32'd404);

    // Misaligned redirect, sticky error.
    step("misalign", 1, 0, 1, 32'h0000_0103);
    chk("misalign_pc", program_counter, 32'h100);
    for (int i = 0; i < 5; i++) step("redir", 1, 1'($urandom_range(0, 1)), 1, 32'h1000 + 32'(i * 16));
    chk("misalign_sticky", {31'b0, misalign_err}, 32'd1);
    step("rst", 0, 0, 0, 0);
    chk("misalign_cleared", {31'b0, misalign_err}, 32'd0);

    // Wrap of PC+4.
    step("redir_top", 1, 0, 1, 32'hFFFF_FFFC);
    step("run", 1, 0, 0, 0);
    chk("wrap_pc4", ifid_pc_plus4, 32'h0000_0000);
    step("run", 1, 0, 0, 0);
    chk("wrap_pc", program_counter, 32'h0000_0004);

    // Reset overrides stall and redirect.
    step("stall", 1, 1, 0, 0);
    step("rst_over", 0, 1, 1, 32'd500);
    chk("rst_over_pc", program_counter, 32'd200);
    chk("rst_over_cnt", fetch_count, 32'd0);
    step("boot", 1, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, s, d;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) >= 3);
      s   = ($urandom_range(0, 99) < 25);
      d   = ($urandom_range(0, 99) < 10);
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) start_pc = {$urandom_range(0, 4095), 2'b00};
      step("rand", r, s, d, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
